// File: rtl/microcode_sequencer.sv
// microcode_sequencer: generates the microcode ROM address each cycle, decodes the
// sequencing field of the returned microword and keeps a small return-address stack.
module microcode_sequencer #(
    parameter int UPC_WIDTH   = 9,
    parameter int WORD_WIDTH  = 88,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_UPC   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [UPC_WIDTH-1:0]  micro_pc,
    input  logic [WORD_WIDTH-1:0] micro_data,
    input  logic [15:0]           cond_flags,
    input  logic [UPC_WIDTH-1:0]  decode_target,
    input  logic                  decode_valid,
    input  logic                  stall,
    input  logic                  resume,
    output logic [WORD_WIDTH-18:0] micro_ctrl,
    output logic                  micro_valid,
    output logic                  seq_error,
    output logic                  illegal_op
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {WAIT, RUN, HALT} state_t;

    state_t               state_q;
    logic [UPC_WIDTH-1:0] upc_q, upc_d, inc, target, npc;
    logic [UPC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [SPW-1:0]       sp_q;
    logic [3:0]           op;
    logic                 err_q, fire, cond, full, empty, push, pop, fault, to_halt;

    assign op     = micro_data[87:84];
    assign target = micro_data[71 +: UPC_WIDTH];
    assign cond   = cond_flags[micro_data[83:80]];
    assign inc    = upc_q + 1'b1;
    assign full   = sp_q == SPW'(STACK_DEPTH);
    assign empty  = sp_q == '0;

    // A dispatch without a valid decoder target waits exactly like a stall.
    assign fire    = state_q == RUN && !stall && !(op == 4'd6 && !decode_valid);
    assign push    = fire && op == 4'd4 && !full;
    assign pop     = fire && op == 4'd5 && !empty;
    assign fault   = fire && ((op == 4'd4 && full) || (op == 4'd5 && empty));
    assign to_halt = fault || (fire && op == 4'd7);

    always_comb begin
        case (op)
            4'd1:    npc = target;
            4'd2:    npc = cond ? target : inc;
            4'd3:    npc = cond ? inc : target;
            4'd4:    npc = full ? inc : target;
            4'd5:    npc = empty ? inc : stack_q[AW'(sp_q - 1'b1)];
            4'd6:    npc = decode_target;
            default: npc = inc;
        endcase
    end

    // Without a fire the ROM re-reads the word it already holds.
    assign upc_d       = fire ? npc : upc_q;
    assign micro_pc    = upc_d;
    assign micro_ctrl  = micro_data[WORD_WIDTH-18:0];
    assign micro_valid = state_q == RUN;
    assign seq_error   = err_q;
    assign illegal_op  = fire && op[3];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= WAIT;
            upc_q   <= UPC_WIDTH'(RESET_UPC);
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            upc_q <= upc_d;
            if (push) begin
                stack_q[sp_q[AW-1:0]] <= inc;
                sp_q                  <= sp_q + 1'b1;
            end
            if (pop)
                sp_q <= sp_q - 1'b1;
            if (fault)
                err_q <= 1'b1;
            case (state_q)
                WAIT:    state_q <= RUN;
                RUN:     state_q <= to_halt ? HALT : RUN;
                HALT:    state_q <= (resume && !err_q) ? RUN : HALT;
                default: state_q <= WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: random stimulus against a ROM-executing reference model;
// expectations are queued per cycle and a monitor compares them at the falling edge.
module tb_microcode_sequencer;
    logic        clock, reset, decode_valid, stall, resume;
    logic [8:0]  micro_pc, decode_target;
    logic [87:0] micro_data;
    logic [15:0] cond_flags;
    logic [70:0] micro_ctrl;
    logic        micro_valid, seq_error, illegal_op;

    microcode_sequencer dut (
        .clock(clock), .reset(reset), .micro_pc(micro_pc), .micro_data(micro_data),
        .cond_flags(cond_flags), .decode_target(decode_target), .decode_valid(decode_valid),
        .stall(stall), .resume(resume), .micro_ctrl(micro_ctrl), .micro_valid(micro_valid),
        .seq_error(seq_error), .illegal_op(illegal_op)
    );

    typedef struct {
        logic [8:0]  pc;
        logic        v, il, er;
        logic [70:0] ctrl;
    } exp_t;

    exp_t        sbq[$];
    logic [87:0] rom [512];
    int          compared = 0, mismatched = 0;

    // Reference model: 0 = warming up after reset, 1 = running, 2 = halted
    int          m_mode;
    logic [8:0]  m_upc;
    logic [8:0]  m_stk[$];
    bit          m_err;

    initial clock = 0;
    always #5 clock = ~clock;

    function automatic logic [87:0] mk(input int op, input int tgt);
        logic [87:0] w;
        w[31:0]  = $urandom;
        w[63:32] = $urandom;
        w[87:64] = 24'($urandom);
        w[87:84] = 4'(op);
        w[83:80] = 4'd3;
        w[79:71] = 9'(tgt);
        return w;
    endfunction

    task automatic chk(input string n, input logic [70:0] got, input logic [70:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, want, $time);
        end
    endtask

    task automatic step(input bit rt, input bit st, input logic [15:0] cf, input bit dv,
                        input logic [8:0] dt, input bit rs);
        exp_t        e;
        logic [87:0] w;
        logic [8:0]  inc, nx, sampled;
        int          op;
        bit          f, hlt;
        reset = rt; stall = st; cond_flags = cf; decode_valid = dv; decode_target = dt; resume = rs;
        w   = rom[m_upc];
        op  = int'(w[87:84]);
        inc = m_upc + 9'd1;
        f   = !rt && m_mode == 1 && !st && !(op == 6 && !dv);
        nx  = m_upc;
        hlt = 0;
        e.v    = !rt && m_mode == 1;
        e.er   = !rt && m_err;
        e.il   = f && op >= 8;
        e.ctrl = w[70:0];
        if (f) begin
            nx = inc;
            case (op)
                1: nx = w[79:71];
                2: if (cf[w[83:80]]) nx = w[79:71];
                3: if (!cf[w[83:80]]) nx = w[79:71];
                4: if (m_stk.size() == 4) begin m_err = 1; hlt = 1; end
                   else begin m_stk.push_back(inc); nx = w[79:71]; end
                5: if (m_stk.size() == 0) begin m_err = 1; hlt = 1; end
                   else nx = m_stk.pop_back();
                6: nx = dt;
                7: hlt = 1;
                default: ;
            endcase
        end
        e.pc = rt ? 9'd0 : nx;
        if (rt) begin
            m_mode = 0; m_upc = 0; m_stk.delete(); m_err = 0;
        end else begin
            m_upc  = nx;
            m_mode = m_mode == 0 ? 1 : m_mode == 1 ? (hlt ? 2 : 1) : ((rs && !m_err) ? 1 : 2);
        end
        sbq.push_back(e);
        @(negedge clock);
        sampled = micro_pc;
        @(posedge clock);
        #1 micro_data = rom[sampled];
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 16'($urandom), 0, 9'h0, 0);
    endtask

    task automatic run(input int n, input int rst_pct, input int stall_pct);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 99) < rst_pct, $urandom_range(0, 99) < stall_pct,
                 16'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1 ? 9'h1A3 : 9'h020, $urandom_range(0, 2) == 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("micro_pc", 71'(micro_pc), 71'(e.pc));
                chk("micro_valid", 71'(micro_valid), 71'(e.v));
                chk("illegal_op", 71'(illegal_op), 71'(e.il));
                chk("seq_error", 71'(seq_error), 71'(e.er));
                if (e.v) chk("micro_ctrl", micro_ctrl, e.ctrl);
            end
        end
    end

    initial begin
        reset = 1; stall = 0; resume = 0; decode_valid = 0; decode_target = 0; cond_flags = 0;
        m_mode = 0; m_upc = 0; m_err = 0;
        for (int a = 0; a < 512; a++) rom[a] = mk(0, $urandom_range(0, 511));
        rom[9'h005] = mk(2, 'h40);  rom[9'h006] = mk(3, 'h40);  rom[9'h007] = mk(1, 'h10);
        rom[9'h041] = mk(1, 'h10);  rom[9'h010] = mk(4, 'h80);  rom[9'h080] = mk(4, 'h90);
        rom[9'h090] = mk(4, 'hA0);  rom[9'h0A0] = mk(4, 'hB0);  rom[9'h0B0] = mk(5, 0);
        rom[9'h0A1] = mk(5, 0);     rom[9'h091] = mk(5, 0);     rom[9'h081] = mk(5, 0);
        rom[9'h011] = mk(6, 0);     rom[9'h1A3] = mk(9, 0);     rom[9'h1A4] = mk(1, 'h1FF);
        rom[9'h1FF] = mk(0, 0);     rom[9'h020] = mk(7, 0);     rom[9'h021] = mk(1, 0);
        micro_data = rom[0];
        @(posedge clock);
        #1;
        hold(3);
        run(400, 1, 25);
        hold(2); rom[9'h0B0] = mk(4, 'hC0); hold(1);
        run(80, 0, 10);
        hold(2); rom[9'h0B0] = mk(5, 0); hold(1);
        run(12, 0, 0);
        hold(2); rom[0] = mk(5, 0); hold(1);
        run(20, 0, 0);
        for (int r = 0; r < 10; r++) begin
            hold(1);
            for (int a = 0; a < 512; a++)
                rom[a] = {mk($urandom_range(0, 3) == 0 ? $urandom_range(8, 15) : $urandom_range(0, 7),
                             $urandom_range(0, 511))} ^ {4'h0, 4'($urandom), 80'h0};
            hold(1);
            run(60, 2, 20);
        end
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
